mem_port_arbiter: RTL

Sequences the multicycle CPU's single 16-bit memory port and shares it between two requesters: the CPU controller (fetch/load/store) and a debug/boot loader port. Each granted access is held stable on the memory for a fixed number of cycles, the read data is captured, and a one-cycle completion pulse goes back to the winner. The block sits between the controller/datapath memory strobes and the memory array. It replaces direct MemRead/MemWrite wiring so the controller can stall on a not-yet-complete access.

---
 rtl/mem_arb_pkg.sv | 29 ++
 rtl/mem_arb_pick.sv | 31 +++
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter.
// State encoding, grant encoding and access latency limits.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_DBG = 1'b1
  } gnt_e;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 7;
  localparam int CNT_W       = 3;

  // Counter preload for a latency, clamped into the legal range.
  function automatic logic [CNT_W-1:0] lat_load(input int lat);
    int l;
    l = lat;
    if (l < MEM_LAT_MIN) l = MEM_LAT_MIN;
    if (l > MEM_LAT_MAX) l = MEM_LAT_MAX;
    return CNT_W'(l - 1);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: grant selection between cpu and dbg requesters.
// MEM_PORT_ARB_RR_EN selects round-robin; otherwise dbg has priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic cpu_req_i,
  input  logic dbg_req_i,
  input  logic last_grant_i,
  output logic grant_o
);

`ifdef MEM_PORT_ARB_RR_EN
  // On a tie, serve whoever was not granted last.
  always_comb begin
    grant_o = GNT_CPU;
    unique case (1'b1)
      cpu_req_i && dbg_req_i:
        grant_o = (last_grant_i == GNT_DBG) ? GNT_CPU : GNT_DBG;
      dbg_req_i && !cpu_req_i:
        grant_o = GNT_DBG;
      default:
        grant_o = GNT_CPU;
    endcase
  end
`else
  logic unused_last;
  assign unused_last = last_grant_i;
  assign grant_o = dbg_req_i ? GNT_DBG : GNT_CPU;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between cpu and dbg.
// Arbitration style set by MEM_PORT_ARB_RR_EN (see mem_arb_pick).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int MEM_LAT = 2
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_done,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_done,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [CNT_W-1:0] LOAD = lat_load(MEM_LAT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  gnt_e             gnt_q, gnt_d;
  logic             mem_en_q, mem_en_d;
  logic             mem_we_q, mem_we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic             cpu_done_q, cpu_done_d;
  logic             dbg_done_q, dbg_done_d;
  logic [DW-1:0]    cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0]    dbg_rdata_q, dbg_rdata_d;
  logic             busy_q, busy_d;
  logic             pick_w;
  gnt_e             pick;

  // gnt_q doubles as the last-grant history for round-robin.
  mem_arb_pick u_pick (
    .cpu_req_i    (cpu_req),
    .dbg_req_i    (dbg_req),
    .last_grant_i (gnt_q),
    .grant_o      (pick_w)
  );

  assign pick = gnt_e'(pick_w);

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_done_d  = 1'b0;
    dbg_done_d  = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    busy_d      = busy_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_req || dbg_req) begin
          state_d  = ACCESS;
          cnt_d    = LOAD;
          gnt_d    = pick;
          mem_en_d = 1'b1;
          busy_d   = 1'b1;
          if (pick == GNT_DBG) begin
            mem_we_d = dbg_we;
            addr_d   = dbg_addr;
            wdata_d  = dbg_wdata;
          end else begin
            mem_we_d = cpu_we;
            addr_d   = cpu_addr;
            wdata_d  = cpu_wdata;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d  = RESP;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          if (gnt_q == GNT_DBG) begin
            dbg_done_d = 1'b1;
            if (!mem_we_q) dbg_rdata_d = mem_rdata;
          end else begin
            cpu_done_d = 1'b1;
            if (!mem_we_q) cpu_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      gnt_q       <= GNT_DBG;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_done_q  <= 1'b0;
      dbg_done_q  <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_done_q  <= cpu_done_d;
      dbg_done_q  <= dbg_done_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_done  = cpu_done_q;
  assign dbg_done  = dbg_done_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign busy      = busy_q;

endmodule
